// File: rtl/sonar_varredura_if.sv
// sonar_varredura_if: trigger/done handshakes between the sweep
// controller and the ultrasonic sensor / serial TX blocks.
interface sonar_varredura_if;
  logic mede;
  logic sensor_pronto;
  logic transmite;
  logic serial_pronto;

  modport master (
    output mede,
    output transmite,
    input  sensor_pronto,
    input  serial_pronto
  );

  modport slave (
    input  mede,
    input  transmite,
    output sensor_pronto,
    output serial_pronto
  );
endinterface

// File: rtl/sonar_varredura.sv
// sonar_varredura: servo sweep controller; dwells, measures and
// ships one distance per position, ping-pong or wrap sweep.
module sonar_varredura #(
  parameter int N_POS     = 8,
  parameter int POS_W     = 3,
  parameter int DWELL     = 100_000_000,
  parameter int DWELL_W   = 27,
  parameter int TIMEOUT   = 2_500_000,
  parameter int TIMEOUT_W = 22
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ligar,
  input  logic             modo,
  sonar_varredura_if.master hs,
  output logic [POS_W-1:0] sel_posicao,
  output logic             direcao,
  output logic             fim_varredura,
  output logic             erro_medida,
  output logic [3:0]       db_estado
);

  typedef enum logic [2:0] {
    INICIAL       = 3'd0,
    POSICIONA     = 3'd1,
    MEDE          = 3'd2,
    ESPERA_MEDIDA = 3'd3,
    TRANSMITE     = 3'd4,
    ESPERA_TX     = 3'd5,
    PROX_POS      = 3'd6
  } estado_t;

  localparam logic [POS_W-1:0] P_ONE =
    POS_W'(1);
  localparam logic [POS_W-1:0] P_LAST =
    POS_W'(N_POS - 1);
  localparam logic [POS_W-1:0] P_PEN =
    POS_W'((N_POS > 1) ? N_POS - 2 : 0);
  localparam logic [DWELL_W-1:0] DW_LAST =
    DWELL_W'(DWELL - 1);
  localparam logic [DWELL_W-1:0] DW_ONE =
    DWELL_W'(1);
  localparam logic [TIMEOUT_W-1:0] TO_LAST =
    TIMEOUT_W'(TIMEOUT - 1);
  localparam logic [TIMEOUT_W-1:0] TO_ONE =
    TIMEOUT_W'(1);
  localparam bit UNICA = (N_POS == 1);

  estado_t              estado;
  logic [DWELL_W-1:0]   dwell_cnt;
  logic [TIMEOUT_W-1:0] tmo_cnt;

  logic             at_last;
  logic             at_zero;
  logic             r_single;
  logic             r_wrap;
  logic             r_up;
  logic             r_down;
  logic [POS_W-1:0] nxt_pos;
  logic             nxt_dir;
  logic             nxt_fim;

  assign db_estado = {1'b0, estado};

  // Next position, evaluated while in PROX_POS.
  always_comb begin
    at_last  = (sel_posicao == P_LAST);
    at_zero  = (sel_posicao == '0);
    r_single = UNICA;
    r_wrap   = !UNICA && modo;
    r_up     = !UNICA && !modo && !direcao;
    r_down   = !UNICA && !modo && direcao;
    nxt_pos  = sel_posicao + P_ONE;
    nxt_dir  = 1'b0;
    nxt_fim  = 1'b0;
    unique case (1'b1)
      r_single: begin
        nxt_pos = '0;
        nxt_fim = 1'b1;
      end
      r_wrap: begin
        if (at_last) begin
          nxt_pos = '0;
          nxt_fim = 1'b1;
        end
      end
      r_up: begin
        if (at_last) begin
          nxt_pos = P_PEN;
          nxt_dir = 1'b1;
          nxt_fim = 1'b1;
        end
      end
      r_down: begin
        nxt_pos = sel_posicao - P_ONE;
        nxt_dir = 1'b1;
        if (at_zero) begin
          nxt_pos = P_ONE;
          nxt_dir = 1'b0;
          nxt_fim = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado        <= INICIAL;
      dwell_cnt     <= '0;
      tmo_cnt       <= '0;
      sel_posicao   <= '0;
      direcao       <= 1'b0;
      erro_medida   <= 1'b0;
      fim_varredura <= 1'b0;
      hs.mede       <= 1'b0;
      hs.transmite  <= 1'b0;
    end else begin
      hs.mede       <= 1'b0;
      hs.transmite  <= 1'b0;
      fim_varredura <= 1'b0;
      if (!ligar) begin
        // erro_medida survives a turn-off on purpose
        estado      <= INICIAL;
        dwell_cnt   <= '0;
        tmo_cnt     <= '0;
        sel_posicao <= '0;
        direcao     <= 1'b0;
      end else begin
        unique case (estado)
          INICIAL: begin
            sel_posicao <= '0;
            direcao     <= 1'b0;
            dwell_cnt   <= '0;
            tmo_cnt     <= '0;
            estado      <= POSICIONA;
          end
          POSICIONA: begin
            if (dwell_cnt == DW_LAST) begin
              dwell_cnt <= '0;
              hs.mede   <= 1'b1;
              estado    <= MEDE;
            end else begin
              dwell_cnt <= dwell_cnt + DW_ONE;
            end
          end
          MEDE: begin
            tmo_cnt <= '0;
            estado  <= ESPERA_MEDIDA;
          end
          ESPERA_MEDIDA: begin
            if (hs.sensor_pronto) begin
              erro_medida  <= 1'b0;
              hs.transmite <= 1'b1;
              tmo_cnt      <= '0;
              estado       <= TRANSMITE;
            end else if (tmo_cnt == TO_LAST) begin
              erro_medida <= 1'b1;
              tmo_cnt     <= '0;
              estado      <= PROX_POS;
            end else begin
              tmo_cnt <= tmo_cnt + TO_ONE;
            end
          end
          TRANSMITE: begin
            estado <= ESPERA_TX;
          end
          ESPERA_TX: begin
            if (hs.serial_pronto) begin
              estado <= PROX_POS;
            end
          end
          PROX_POS: begin
            sel_posicao   <= nxt_pos;
            direcao       <= nxt_dir;
            fim_varredura <= nxt_fim;
            estado        <= POSICIONA;
          end
          default: begin
            estado <= INICIAL;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sonar_varredura.sv
// tb_sonar_varredura: directed sweeps checked against a per-cycle
// protocol model plus literal position/pulse sequences.
module tb_sonar_varredura;
  localparam int N   = 4;
  localparam int PW  = 3;
  localparam int DW  = 5;
  localparam int TO  = 10;

  logic          clock = 1'b0;
  logic          reset;
  logic          ligar;
  logic          modo;
  logic [PW-1:0] sel;
  logic          direcao;
  logic          fim;
  logic          erro;
  logic [3:0]    db;

  int checks = 0;
  int errors = 0;

  sonar_varredura_if hs();

  sonar_varredura #(
    .N_POS(N), .POS_W(PW), .DWELL(DW), .DWELL_W(4),
    .TIMEOUT(TO), .TIMEOUT_W(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .ligar(ligar),
    .modo(modo),
    .hs(hs.master),
    .sel_posicao(sel),
    .direcao(direcao),
    .fim_varredura(fim),
    .erro_medida(erro),
    .db_estado(db)
  );

  always #5 clock = ~clock;

  task automatic chk_eq(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // Sweep rules straight from the position arithmetic.
  function automatic void model_next(input int p, input bit d, input bit m,
                                     output int np, output bit nd, output bit nf);
    nf = 1'b0;
    nd = 1'b0;
    if (m) begin
      np = (p + 1) % N;
      nf = (p == N - 1);
    end else if (!d) begin
      if (p < N - 1) np = p + 1;
      else begin np = N - 2; nd = 1'b1; nf = 1'b1; end
    end else begin
      if (p > 0) begin np = p - 1; nd = 1'b1; end
      else begin np = 1; nf = 1'b1; end
    end
  endfunction

  int prev_st = 0;
  int prev_sel = 0;
  bit prev_dir = 1'b0;
  bit prev_modo = 1'b0;
  int run_p = 0;
  int run_e = 0;
  int q_sel[$];
  int q_fim[$];
  int q_dir[$];

  always @(negedge clock) begin
    int st, np;
    bit nd, nf;
    if (reset) begin
      prev_st = 0; prev_sel = 0; prev_dir = 1'b0;
      run_p = 0; run_e = 0;
    end else begin
      st = int'(db);
      chk_eq("mon_state_legal", int'(st <= 6), 1);
      chk_eq("mon_mede", int'(hs.mede), int'(st == 2));
      chk_eq("mon_transmite", int'(hs.transmite), int'(st == 4));
      if (st == 1 && prev_st == 6) begin
        model_next(prev_sel, prev_dir, prev_modo, np, nd, nf);
        chk_eq("mon_next_pos", int'(sel), np);
        chk_eq("mon_next_dir", int'(direcao), int'(nd));
        chk_eq("mon_fim", int'(fim), int'(nf));
      end else begin
        chk_eq("mon_fim_idle", int'(fim), 0);
        if (st == 0 || prev_st == 0) begin
          chk_eq("mon_home_pos", int'(sel), 0);
          chk_eq("mon_home_dir", int'(direcao), 0);
        end else begin
          chk_eq("mon_pos_stable", int'(sel), prev_sel);
          chk_eq("mon_dir_stable", int'(direcao), int'(prev_dir));
        end
      end
      if (st == 1) run_p = (prev_st == 1) ? run_p + 1 : 1;
      if (st == 2) chk_eq("mon_dwell_len", run_p, DW);
      if (st == 3) run_e = (prev_st == 3) ? run_e + 1 : 1;
      if (prev_st == 3 && st == 6) begin
        chk_eq("mon_timeout_len", run_e, TO);
        chk_eq("mon_timeout_erro", int'(erro), 1);
      end
      if (prev_st == 3 && st == 4)
        chk_eq("mon_ok_erro", int'(erro), 0);
      if (st == 1 && prev_st != 1) begin
        q_sel.push_back(int'(sel));
        q_fim.push_back(int'(fim));
        q_dir.push_back(int'(direcao));
      end
      prev_st = st;
      prev_sel = int'(sel);
      prev_dir = direcao;
      prev_modo = modo;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_state(input int s, input string nm);
    int n = 0;
    do begin step(); n++; end while (int'(db) != s && n < 300);
    chk_eq(nm, int'(db), s);
  endtask

  task automatic wait_pos(input int p, input bit d, input string nm);
    int n = 0;
    do begin step(); n++; end
    while (!(int'(db) == 1 && int'(sel) == p && direcao == d) && n < 300);
    chk_eq(nm, int'(int'(db) == 1 && int'(sel) == p && direcao == d), 1);
  endtask

  task automatic wait_q(input int cnt, input string nm);
    int n = 0;
    while (q_sel.size() < cnt && n < 400) begin step(); n++; end
    chk_eq(nm, int'(q_sel.size() >= cnt), 1);
  endtask

  task automatic clear_q();
    q_sel.delete();
    q_fim.delete();
    q_dir.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int pp_sel[8] = '{0, 1, 2, 3, 2, 1, 0, 1};
    int pp_fim[8] = '{0, 0, 0, 0, 1, 0, 0, 1};
    int wr_sel[6] = '{0, 1, 2, 3, 0, 1};
    int wr_fim[6] = '{0, 0, 0, 0, 1, 0};
    int n, saved, bad, e;
    bit txs;

    reset = 1'b1; ligar = 1'b0; modo = 1'b0;
    hs.sensor_pronto = 1'b1;
    hs.serial_pronto = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk_eq("rst_db", int'(db), 0);
    chk_eq("rst_sel", int'(sel), 0);
    chk_eq("rst_dir", int'(direcao), 0);
    chk_eq("rst_erro", int'(erro), 0);
    chk_eq("rst_mede", int'(hs.mede), 0);
    chk_eq("rst_tx", int'(hs.transmite), 0);
    chk_eq("rst_fim", int'(fim), 0);
    reset = 1'b0;
    step();

    // ping-pong sweep
    clear_q();
    ligar = 1'b1;
    wait_q(8, "pp_collect");
    for (int i = 0; i < 8 && i < q_sel.size(); i++) begin
      chk_eq($sformatf("pp_sel[%0d]", i), q_sel[i], pp_sel[i]);
      chk_eq($sformatf("pp_fim[%0d]", i), q_fim[i], pp_fim[i]);
    end

    // wrap sweep from a fresh start
    ligar = 1'b0;
    step();
    chk_eq("wr_off_db", int'(db), 0);
    modo = 1'b1;
    clear_q();
    ligar = 1'b1;
    wait_q(6, "wr_collect");
    for (int i = 0; i < 6 && i < q_sel.size(); i++) begin
      chk_eq($sformatf("wr_sel[%0d]", i), q_sel[i], wr_sel[i]);
      chk_eq($sformatf("wr_fim[%0d]", i), q_fim[i], wr_fim[i]);
      chk_eq($sformatf("wr_dir[%0d]", i), q_dir[i], 0);
    end

    // measurement timeout
    hs.sensor_pronto = 1'b0;
    wait_state(2, "to_reach_mede");
    chk_eq("to_mede", int'(hs.mede), 1);
    n = 0;
    txs = 1'b0;
    do begin
      step();
      n++;
      if (hs.transmite) txs = 1'b1;
    end while (int'(db) != 6 && n < 40);
    chk_eq("to_latency", n, TO + 1);
    chk_eq("to_erro", int'(erro), 1);
    chk_eq("to_no_tx", int'(txs), 0);
    hs.sensor_pronto = 1'b1;
    wait_state(4, "to_next_tx");
    chk_eq("to_erro_clear", int'(erro), 0);

    // serial stall
    hs.serial_pronto = 1'b0;
    wait_state(5, "stall_reach");
    saved = int'(sel);
    bad = 0;
    repeat (50) begin
      step();
      if (int'(db) != 5 || int'(sel) != saved) bad++;
    end
    chk_eq("stall_hold", bad, 0);
    hs.serial_pronto = 1'b1;
    step();
    chk_eq("stall_release_db", int'(db), 6);
    chk_eq("stall_release_sel", int'(sel), saved);

    // turn-off at position 2 descending
    ligar = 1'b0;
    step();
    modo = 1'b0;
    ligar = 1'b1;
    wait_pos(2, 1'b1, "off_reach");
    e = int'(erro);
    ligar = 1'b0;
    step();
    chk_eq("off_db", int'(db), 0);
    chk_eq("off_sel", int'(sel), 0);
    chk_eq("off_dir", int'(direcao), 0);
    chk_eq("off_erro_held", int'(erro), e);

    // async reset mid-dwell with erro_medida set
    ligar = 1'b1;
    hs.sensor_pronto = 1'b0;
    wait_state(6, "ar_timeout");
    chk_eq("ar_erro_set", int'(erro), 1);
    hs.sensor_pronto = 1'b1;
    wait_state(1, "ar_dwell");
    step();
    chk_eq("ar_sel_before", int'(sel), 1);
    #2 reset = 1'b1;
    #1;
    chk_eq("ar_db", int'(db), 0);
    chk_eq("ar_sel", int'(sel), 0);
    chk_eq("ar_dir", int'(direcao), 0);
    chk_eq("ar_erro", int'(erro), 0);
    chk_eq("ar_mede", int'(hs.mede), 0);
    chk_eq("ar_tx", int'(hs.transmite), 0);
    chk_eq("ar_fim", int'(fim), 0);
    step();
    reset = 1'b0;
    repeat (3) step();
    chk_eq("ar_restart_db", int'(db), 1);
    chk_eq("ar_restart_sel", int'(sel), 0);

    // sensor_pronto in the timeout cycle wins
    hs.sensor_pronto = 1'b0;
    wait_state(6, "sim_prior_to");
    wait_state(2, "sim_mede");
    repeat (TO) step();
    chk_eq("sim_last_wait_db", int'(db), 3);
    chk_eq("sim_last_wait_erro", int'(erro), 1);
    hs.sensor_pronto = 1'b1;
    step();
    chk_eq("sim_db", int'(db), 4);
    chk_eq("sim_tx", int'(hs.transmite), 1);
    chk_eq("sim_erro", int'(erro), 0);

    // modo 0->1 at position 2 descending
    wait_pos(2, 1'b1, "mc_reach");
    modo = 1'b1;
    wait_state(6, "mc_prox");
    step();
    chk_eq("mc_db", int'(db), 1);
    chk_eq("mc_sel", int'(sel), 3);
    chk_eq("mc_dir", int'(direcao), 0);
    chk_eq("mc_fim", int'(fim), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sonar_varredura.md
# sonar_varredura

Parametrised sweep controller for the sonar: steps the servo through `N_POS` positions and dwells at each one. At each position it triggers one distance measurement and hands the result to the serial transmitter, then advances. It supports round-trip (ping-pong) and one-way (wrap) sweeps and a measurement timeout. It sits between the servo PWM position selector, the ultrasonic sensor interface and the serial TX path.

## Interface
- `N_POS`, 8: number of servo positions, ≥1.
- `POS_W`, 3: width of `sel_posicao`; must satisfy 2^POS_W ≥ N_POS.
- `DWELL`, 100_000_000: clock cycles spent in POSICIONA per position, ≥1 (2 s at 50 MHz).
- `DWELL_W`, 27: width of the dwell counter; 2^DWELL_W ≥ DWELL.
- `TIMEOUT`, 2_500_000: maximum cycles spent waiting for `sensor_pronto`, ≥1.
- `TIMEOUT_W`, 22: width of the timeout counter.

Ports (one clock; reset is asynchronous and active-high):
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high; forces every register to its reset value.
- `ligar`  in  1  enable; a low level returns the block to INICIAL on the next edge.
- `modo`  in  1  0 = ping-pong, 1 = wrap (N_POS-1 → 0); sampled only in PROX_POS.
- `sensor_pronto`  in  1  measurement-done pulse or level.
- `serial_pronto`  in  1  transmission-done pulse or level.
- `mede`  out  1  one-cycle sensor trigger.
- `transmite`  out  1  one-cycle serial start.
- `sel_posicao`  out  POS_W  current servo position.
- `direcao`  out  1  0 = ascending, 1 = descending.
- `fim_varredura`  out  1  one-cycle pulse when an endpoint is reached.
- `erro_medida`  out  1  sticky flag: the last measurement timed out.
- `db_estado`  out  4  state code, zero-extended.

## Operation
- States and codes: INICIAL=0, POSICIONA=1, MEDE=2, ESPERA_MEDIDA=3, TRANSMITE=4, ESPERA_TX=5, PROX_POS=6. Unused codes go to INICIAL.
- **INICIAL**
  - `sel_posicao`←0, `direcao`←0, counters←0.
  - Goes to POSICIONA when `ligar`=1.
- **POSICIONA**
  - The dwell counter increments each cycle.
  - At count DWELL-1 the counter clears and the block goes to MEDE.
- **MEDE**
  - `mede`=1 for this single cycle.
  - Timeout counter clears; always goes to ESPERA_MEDIDA.
- **ESPERA_MEDIDA**
  - `sensor_pronto`=1: `erro_medida`←0, go to TRANSMITE.
  - Otherwise, at timeout count TIMEOUT-1: `erro_medida`←1, go to PROX_POS. Transmission is skipped.
  - `sensor_pronto` takes priority over timeout in the same cycle.
- **TRANSMITE**
  - `transmite`=1 for one cycle, then ESPERA_TX.
- **ESPERA_TX**
  - Waits indefinitely for `serial_pronto`=1, then goes to PROX_POS.
- **PROX_POS** (one cycle): updates position per the rules below, then goes to POSICIONA.
  - Ping-pong, ascending: below N_POS-1, +1. At N_POS-1: `direcao`←1, position←N_POS-2, `fim_varredura`=1. Endpoints are never repeated.
  - Ping-pong, descending: mirror image. At 0: `direcao`←0, position←1, `fim_varredura`=1.
  - Wrap: `direcao` forced 0. At N_POS-1 position←0 and `fim_varredura`=1; otherwise +1.
  - N_POS=1: position stays 0; `fim_varredura`=1 on every PROX_POS.
- **Mode change:** switching `modo` to wrap while descending sets `direcao`←0 and applies the wrap rule from the current position.
- **`ligar` low:** from any state, the next edge enters INICIAL. Position and direction reset to 0; `erro_medida` is held.
- **Pulse outputs:** `mede`, `transmite` and `fim_varredura` are Moore outputs of the state/transition. They never assert for more than one cycle per visit.

## Timing
- **Reset values:** state INICIAL, `sel_posicao`=0, `direcao`=0, `erro_medida`=0, `mede`=`transmite`=`fim_varredura`=0, `db_estado`=0.
- **Cycle latency per position** with an immediate handshake: 1 (INICIAL, first position only) + DWELL + 1 (MEDE) + 1 (ESP_MED) + 1 (TX) + 1 (ESP_TX) + 1 (PROX_POS).
- **Handshake latency:** `sensor_pronto`/`serial_pronto` seen at edge k causes the transition at edge k. The pulse output follows in the cycle after.
- **Register updates:** `sel_posicao` and `direcao` update at the edge leaving PROX_POS and are stable for the whole dwell.
- **Timeout:** with no `sensor_pronto`, the block leaves ESPERA_MEDIDA exactly TIMEOUT cycles after MEDE.
- **Asynchronous reset mid-operation:** immediate return to the reset values, with no pulse glitches after release.

## Test plan
Bench parameters: N_POS=4, DWELL=5, TIMEOUT=10.

- **Ping-pong sweep:** `modo`=0 with instant handshakes.
  - `sel_posicao` sequence is 0,1,2,3,2,1,0,1.
  - `fim_varredura` pulses at the 3→2 and 0→1 steps.
  - Each POSICIONA lasts exactly 5 cycles.
- **Wrap sweep:** `modo`=1.
  - Sequence is 0,1,2,3,0,1 with `direcao`=0 throughout.
  - `fim_varredura` pulses at 3→0.
- **Timeout:** hold `sensor_pronto`=0.
  - Exactly 10 cycles after `mede`, `erro_medida`=1 and the state goes to PROX_POS.
  - `transmite` never pulses.
  - The next successful measurement clears `erro_medida`.
- **Serial stall:** hold `serial_pronto`=0 for 50 cycles.
  - The block stays in ESPERA_TX (`db_estado`=5) and `sel_posicao` is unchanged.
  - Releasing it gives PROX_POS on the next cycle.
- **Turn-off and reset mid-sweep:**
  - Drop `ligar` at position 2 descending: the next edge shows `db_estado`=0, `sel_posicao`=0, `direcao`=0.
  - Assert `reset` asynchronously mid-dwell: all outputs take their reset values immediately.
- **Simultaneous events and mode change:**
  - `sensor_pronto` arriving in the timeout cycle goes to TRANSMITE with `erro_medida`=0.
  - Switching `modo` 0→1 at position 2 descending gives next position 3 with `direcao`=0.
